// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// States, default frame constants and the 3-sample majority vote.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// ResetValue sets the state both flops take while rst_ni is low.
module sync_2ff #(
  parameter bit ResetValue = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{ResetValue}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned Mid   = OVERSAMPLE / 2;
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned CntW  = $clog2(DATA_BITS);

  localparam logic [TickW-1:0] TickSamp0 = TickW'(Mid - 1);
  localparam logic [TickW-1:0] TickSamp1 = TickW'(Mid);
  localparam logic [TickW-1:0] TickDec   = TickW'(Mid + 1);
  localparam logic [TickW-1:0] TickLast  = TickW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0]  CntLast   = CntW'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (data_in),
    .q_o   (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 armed_q, armed_d;
  logic                 par_q, par_d;

  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 parity_err_q, parity_err_d;

  logic maj;
  logic at_dec;
  logic at_end;
  logic stop_dec;
  logic stop_bit;
  logic par_bad;

  assign maj    = maj3(samp_q[0], samp_q[1], rx_s);
  assign at_dec = (tick_q == TickDec);
  assign at_end = (tick_q == TickLast);

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus the received parity bit must XOR to zero.
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  // Frame sequencing
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    armed_d   = armed_q;
    par_d     = par_q;
    stop_dec  = 1'b0;
    stop_bit  = 1'b0;

    if (state_q != StIdle) begin
      tick_d = at_end ? '0 : tick_q + 1'b1;
      if (tick_q == TickSamp0) samp_d[0] = rx_s;
      if (tick_q == TickSamp1) samp_d[1] = rx_s;
    end

    unique case (state_q)
      StIdle: begin
        tick_d = '0;
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // The detect cycle itself is tick 0 of the start bit.
          state_d = StStart;
          tick_d  = TickW'(1);
          armed_d = 1'b0;
        end
      end
      StStart: begin
        if (at_dec && maj) begin
          state_d = StIdle;
          tick_d  = '0;
        end else if (at_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        // Shift in from the top so the first bit ends up at index 0.
        if (at_dec) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_cnt_q == CntLast) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (at_dec) par_d = maj;
        if (at_end) state_d = StStop;
      end
`endif
      StStop: begin
        // Leave mid stop bit so the next start edge is never missed.
        if (at_dec) begin
          state_d  = StIdle;
          tick_d   = '0;
          stop_dec = 1'b1;
          stop_bit = maj;
        end
      end
      default: begin
        state_d = StIdle;
        tick_d  = '0;
      end
    endcase
  end

  // Holding register, handshake and error pulses
  always_comb begin
    data_out_d   = data_out_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    if (stop_dec) begin
      if (par_bad) begin
        parity_err_d = 1'b1;
      end else if (!stop_bit) begin
        frame_err_d = 1'b1;
      end else if (!valid_q || ready) begin
        data_out_d = shift_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      samp_q       <= '0;
      armed_q      <= 1'b0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      samp_q       <= samp_d;
      armed_q      <= armed_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver; downstream counterpart of the team's uart_tx on the serial link.
- Frame format: 1 start bit (0), DATA_BITS data bits sent LSB first, 1 stop bit (1), each bit OVERSAMPLE clk periods long. One extra parity bit when the macro is enabled.
- Recovers bytes, checks framing and presents each byte on a valid/ready interface with a one-entry holding register.

Parameters:
- OVERSAMPLE, 16, clk cycles per bit; must be >= 8. Define MID = OVERSAMPLE/2.
- DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
- clk, input, 1, sampling clock (OVERSAMPLE x baud).
- rst_n, input, 1, asynchronous active-low reset.
- data_in, input, 1, serial line; asynchronous to clk; idles high.
- data_out, output, DATA_BITS, received byte; stable while valid=1.
- valid, output, 1, data_out holds an unconsumed byte.
- ready, input, 1, consumer accepts data_out when valid && ready.
- frame_err, output, 1, one-cycle pulse: stop bit sampled 0.
- overrun, output, 1, one-cycle pulse: completed byte dropped because buffer full.
- parity_err, output, 1, one-cycle pulse: parity mismatch; tied 0 without the macro.

Behaviour:
- Reset: data_out=0, valid=0, frame_err=0, overrun=0, parity_err=0. FSM goes to IDLE, bit counter and tick counter go to 0. Synchronizer flops reset to 1. armed=0.
- Input path: data_in passes through a 2-FF synchronizer (rx_s), adding 2 cycles of latency. All decisions use rx_s.
- armed: set when rx_s=1 while in IDLE. Start detection requires armed=1, so a line stuck low (break) never re-triggers.
- Tick counter: runs 0..OVERSAMPLE-1 inside each bit and wraps to 0 at the bit boundary.
- Bit decision: majority of rx_s samples taken at ticks MID-1, MID and MID+1, decided at tick MID+1.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE: when armed && rx_s==0, go to START with tick=1 (the detect cycle counts as tick 0), and clear armed.
- START: at the decision point, majority 1 means a false start: return to IDLE with no output. Majority 0: continue to the bit boundary, then go to DATA.
- DATA: shift the decided bit into bit index bit_cnt (LSB first). After bit DATA_BITS-1 reaches its boundary, go to PARITY or STOP.
- STOP: at the decision point (mid stop bit), return to IDLE immediately; do not wait for the end of the stop bit. This allows back-to-back frames with up to MID-2 cycles of clock mismatch.
  - Stop=1 and no error: commit the byte.
  - Stop=0: pulse frame_err the next cycle and discard the byte.
- Commit, taking effect the cycle after the stop decision:
  - If valid==0, or valid && ready in that same cycle: load data_out and set valid=1.
  - Otherwise keep the old byte, drop the new one and pulse overrun.
- Handshake: valid falls the cycle after valid && ready, unless a commit lands in that same cycle, in which case valid stays 1 with the new byte. data_out never changes while valid && !ready.
- Latency: valid rises (2 + OVERSAMPLE*(1+DATA_BITS) + MID + 2) cycles after the data_in falling edge. This is 2+144+8+2 = 156 at default parameters.
- Error pulses are mutually exclusive per frame. A parity error takes priority over a frame error.
- Reset asserted mid-frame: immediate return to IDLE. The partial byte is lost and no pulses are produced.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA. It expects even parity (XOR of the data bits and the parity bit equals 0). On a mismatch, parity_err pulses the cycle after the stop decision and the byte is discarded. Frame length becomes DATA_BITS+3 bits.
- Undefined: no PARITY state, parity_err is constant 0, and the frame is DATA_BITS+2 bits, compatible with uart_tx.

Decomposition:
- Package uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, PARITY, STOP);
  - the default constants OVERSAMPLE_DEF=16 and DATA_BITS_DEF=8;
  - a function maj3(a,b,c).
- One sub-module, sync_2ff: a 2-flop synchronizer with an asynchronous active-low reset and a reset-value parameter (1 here).

Test Plan:
- Frame 0xA5 at 16 ticks/bit with ready=1 -> valid pulses once, data_out=0xA5, 156 cycles after the falling edge; no error pulses.
- Glitch low for 5 cycles in idle -> false start, valid stays 0, back in IDLE.
- Frames 0x3C then 0xC3 back-to-back with ready=0 -> data_out holds 0x3C, overrun pulses once, 0xC3 is dropped. Raise ready -> valid drops.
- Frame 0x55 with stop bit 0 -> frame_err pulses for 1 cycle, valid stays 0. Line held low afterwards -> no new start until data_in returns high.
- Single-cycle glitch inverting a sample at tick MID inside data bit 3 of 0x0F -> majority vote still gives 0x0F.
- rst_n pulsed low during bit 4 of a frame -> all outputs 0. The next full frame 0x81 is received correctly. With UART_RX_PARITY_EN defined, 0x81 with parity bit 1 -> parity_err pulses and valid stays 0.
